// File: rtl/hpdcache_rsp_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hpdcache_rsp_router_pkg
//  Purpose  : Shared helpers for the response router. This package provides
//             the index-width function and the default sizing constants.
//  Revision : 1.0 - initial release
// ============================================================================
package hpdcache_rsp_router_pkg;

  localparam int unsigned C_DEFAULT_N     = 4;
  localparam int unsigned C_DEFAULT_DEPTH = 8;

  // Width of a requester index. It is never zero, so the design also works
  // when there is a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpdcache_rsp_router_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : hpdcache_rsp_router_fifo
//  Purpose  : DEPTH-entry FIFO of requester indices. It has no bypass path,
//             so a pushed entry first becomes visible at the head on the
//             following cycle.
//  Ports    : clk_i, rst_ni (async, active-low)
//             push_i/data_i  - enqueue (ignored when full)
//             pop_i          - dequeue head (ignored when empty)
//             data_o         - head entry
//             count_o/full_o/empty_o - occupancy status
//  Revision : 1.0 - initial release
// ============================================================================
module hpdcache_rsp_router_fifo
  import hpdcache_rsp_router_pkg::*;
#(
  parameter  int unsigned DEPTH = C_DEFAULT_DEPTH,
  parameter  int unsigned WIDTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == CNT_W'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd_ptr];

  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  // The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The storage needs no reset. A slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/hpdcache_rsp_router.sv
`default_nettype none
// ============================================================================
//  Module   : hpdcache_rsp_router
//  Purpose  : Return path of the fixed-priority request arbiter. The module
//             records the winning requester of every issued request in grant
//             order. It then routes the in-order downstream responses back to
//             that requester. When the table is full, it back-pressures the
//             request path.
//  Ports    : clk_i, rst_ni (async, active-low)
//             alloc_valid_i/alloc_ready_o/alloc_gnt_i - request-side record
//             rsp_valid_i/rsp_ready_o                 - shared response
//             rsp_valid_o/rsp_ready_i                 - per-requester response
//             outstanding_o, empty_o                  - occupancy status
//             err_o  - sticky protocol error (only with
//                      HPDCACHE_RSP_ROUTER_ERR_EN defined)
//  Revision : 1.0 - initial release
// ============================================================================
module hpdcache_rsp_router
  import hpdcache_rsp_router_pkg::*;
#(
  parameter int unsigned N     = C_DEFAULT_N,
  parameter int unsigned DEPTH = C_DEFAULT_DEPTH
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         alloc_valid_i,
  output logic                         alloc_ready_o,
  input  logic [N-1:0]                 alloc_gnt_i,
  input  logic                         rsp_valid_i,
  output logic                         rsp_ready_o,
  output logic [N-1:0]                 rsp_valid_o,
  input  logic [N-1:0]                 rsp_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         empty_o
`ifdef HPDCACHE_RSP_ROUTER_ERR_EN
  ,
  output logic                         err_o
`endif
);

  localparam int unsigned IDX_W = idx_width(N);

  logic [IDX_W-1:0] w_alloc_idx;
  logic             w_gnt_any;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [IDX_W-1:0] w_head;
  logic [N-1:0]     w_head_sel;
  logic             w_head_ready;

  // Lowest-set-bit encoder. It uses the same priority as the arbiter, so a
  // malformed grant still records the requester the arbiter favours.
  always_comb begin
    w_alloc_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (alloc_gnt_i[i]) w_alloc_idx = IDX_W'(i);
    end
  end

  assign w_gnt_any     = |alloc_gnt_i;
  // The ready output comes only from the registered count. This keeps it
  // free of any combinational path from the response side.
  assign alloc_ready_o = ~w_full;
  assign w_push        = alloc_valid_i & alloc_ready_o & w_gnt_any;

  hpdcache_rsp_router_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IDX_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .data_i  (w_alloc_idx),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .count_o (outstanding_o),
    .full_o  (w_full),
    .empty_o (empty_o)
  );

  // Index-to-one-hot decode of the head requester.
  always_comb begin
    w_head_sel = '0;
    for (int i = 0; i < N; i++) begin
      w_head_sel[i] = (w_head == IDX_W'(i));
    end
  end

  assign w_head_ready = |(w_head_sel & rsp_ready_i);
  assign rsp_valid_o  = (rsp_valid_i & ~empty_o) ? w_head_sel : '0;
  assign w_pop        = rsp_valid_i & ~empty_o & w_head_ready;

`ifdef HPDCACHE_RSP_ROUTER_ERR_EN
  logic w_gnt_onehot;
  logic w_err_evt;
  logic r_err;

  // When the table is empty, an arriving response is accepted and dropped.
  // Ready follows valid in that case, so it stays low while the table is
  // idle.
  assign rsp_ready_o  = empty_o ? rsp_valid_i : w_head_ready;
  assign w_gnt_onehot = w_gnt_any & ((alloc_gnt_i & (alloc_gnt_i - 1'b1)) == '0);
  assign w_err_evt    = (alloc_valid_i & (~w_gnt_onehot | w_full))
                      | (rsp_valid_i & empty_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign rsp_ready_o = ~empty_o & w_head_ready;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hpdcache_rsp_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hpdcache_rsp_router
//  Purpose  : Self-checking bench for hpdcache_rsp_router (N=4, DEPTH=8).
//             It runs directed scenarios and then randomized traffic. The
//             reference model is a queue of requester indices.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hpdcache_rsp_router;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 8;
`ifdef HPDCACHE_RSP_ROUTER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic         clk_i;
  logic         rst_ni;
  logic         alloc_valid_i;
  logic         alloc_ready_o;
  logic [N-1:0] alloc_gnt_i;
  logic         rsp_valid_i;
  logic         rsp_ready_o;
  logic [N-1:0] rsp_valid_o;
  logic [N-1:0] rsp_ready_i;
  logic [3:0]   outstanding_o;
  logic         empty_o;
  logic         err_o;

  hpdcache_rsp_router #(.N(N), .DEPTH(DEPTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .alloc_valid_i (alloc_valid_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_gnt_i   (alloc_gnt_i),
    .rsp_valid_i   (rsp_valid_i),
    .rsp_ready_o   (rsp_ready_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .outstanding_o (outstanding_o),
    .empty_o       (empty_o)
`ifdef HPDCACHE_RSP_ROUTER_ERR_EN
    ,
    .err_o         (err_o)
`endif
  );

`ifndef HPDCACHE_RSP_ROUTER_ERR_EN
  assign err_o = 1'b0;
`endif

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the requester indices in issue order, plus the sticky error.
  int q[$];
  bit m_err;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input bit av, input logic [N-1:0] gnt, input bit rv, input logic [N-1:0] rr);
    alloc_valid_i = av;
    alloc_gnt_i   = gnt;
    rsp_valid_i   = rv;
    rsp_ready_i   = rr;
  endtask

  // Inputs are set at the falling edge. This task checks every output
  // against the model and then advances the model across one rising edge.
  task automatic step();
    bit         ne;
    int         head;
    int         pidx;
    logic [N-1:0] ev;
    bit         er;
    bit         do_push;
    bit         do_pop;
    bit         gnt_onehot;
    bit         viol;
    #1;
    ne   = (q.size() != 0);
    head = ne ? q[0] : 0;
    ev   = (ne && rsp_valid_i) ? N'(1 << head) : '0;
    if (ne)          er = rsp_ready_i[head];
    else if (ERR_EN) er = rsp_valid_i;
    else             er = 1'b0;

    check_value("empty_o",       32'(empty_o),       32'(!ne));
    check_value("outstanding_o", 32'(outstanding_o), 32'(q.size()));
    check_value("alloc_ready_o", 32'(alloc_ready_o), 32'(q.size() != DEPTH));
    check_value("rsp_valid_o",   32'(rsp_valid_o),   32'(ev));
    check_value("rsp_ready_o",   32'(rsp_ready_o),   32'(er));
    if (ERR_EN) check_value("err_o", 32'(err_o), 32'(m_err));

    pidx = -1;
    for (int i = 0; i < N; i++) if (alloc_gnt_i[i] && pidx < 0) pidx = i;
    do_push    = alloc_valid_i && (q.size() != DEPTH) && (pidx >= 0);
    do_pop     = ne && rsp_valid_i && er;
    gnt_onehot = ($countones(alloc_gnt_i) == 1);
    viol       = (alloc_valid_i && (!gnt_onehot || q.size() == DEPTH)) || (rsp_valid_i && !ne);

    @(posedge clk_i);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(pidx);
    if (viol)    m_err = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    drive(0, '0, 0, '0);
    rst_ni = 1'b0;
    q.delete();
    m_err = 1'b0;
    @(negedge clk_i);
    check_value("rst empty_o",       32'(empty_o),       32'd1);
    check_value("rst outstanding_o", 32'(outstanding_o), 32'd0);
    check_value("rst rsp_valid_o",   32'(rsp_valid_o),   32'd0);
    check_value("rst alloc_ready_o", 32'(alloc_ready_o), 32'd1);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni = 1'b1;
    m_err  = 1'b0;
    drive(0, '0, 0, '0);
    @(negedge clk_i);
    do_reset();

    // Three grants, then three responses with every ready bit set.
    drive(1, 4'b0100, 0, '0); step();
    drive(1, 4'b0001, 0, '0); step();
    drive(1, 4'b1000, 0, '0); step();
    drive(0, '0, 1, 4'b1111); #1 check_value("order0", 32'(rsp_valid_o), 32'b0100); step();
    drive(0, '0, 1, 4'b1111); #1 check_value("order1", 32'(rsp_valid_o), 32'b0001); step();
    drive(0, '0, 1, 4'b1111); #1 check_value("order2", 32'(rsp_valid_o), 32'b1000); step();
    drive(0, '0, 0, '0); step();

    // Fill the table to DEPTH, then free one slot.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, N'(1 << (i % N)), 0, '0); step();
    end
    drive(0, '0, 0, '0); #1 check_value("full ready", 32'(alloc_ready_o), 32'd0); step();
    drive(0, '0, 1, 4'b1111); step();
    drive(0, '0, 0, '0); #1 check_value("freed ready", 32'(alloc_ready_o), 32'd1); step();

    // Reset in the middle of traffic discards every entry.
    drive(0, '0, 1, 4'b0000);
    do_reset();

    // The head is requester 2 and only the other ready bits are set.
    drive(1, 4'b0100, 0, '0); step();
    drive(0, '0, 1, 4'b1011); step();
    drive(0, '0, 1, 4'b1011); #1 check_value("held valid", 32'(rsp_valid_o), 32'b0100); step();
    drive(0, '0, 1, 4'b0100); step();
    drive(0, '0, 0, '0); #1 check_value("popped", 32'(empty_o), 32'd1); step();

    // Push and pop in the same cycle at count 3.
    for (int i = 0; i < 3; i++) begin
      drive(1, 4'b0010, 0, '0); step();
    end
    drive(1, 4'b0001, 1, 4'b1111); step();
    drive(0, '0, 0, '0); #1 check_value("pushpop count", 32'(outstanding_o), 32'd3); step();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1, 4'b1111); step();
    end
    // A push into the empty table is not routed in the same cycle.
    drive(1, 4'b1000, 1, 4'b1111); #1 check_value("no bypass", 32'(rsp_valid_o), 32'd0); step();
    drive(0, '0, 1, 4'b1111); step();

    do_reset();
    // A malformed grant encodes its lowest set bit.
    drive(1, 4'b0110, 0, '0); step();
    drive(0, '0, 1, 4'b1111); #1 check_value("lsb idx", 32'(rsp_valid_o), 32'b0010); step();
    drive(0, '0, 0, '0); step();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] gnt;
      gnt = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'(1 << $urandom_range(0, N - 1));
      drive($urandom_range(0, 1), gnt, ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom));
      step();
      if (c == 300) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
